event_indicator: RTL
====================

// Module: event_indicator
// PURPOSE
//   Output-side counterpart of the button input path: turns single-cycle event pulses
//   (from the debounced/one-shot button logic or any FSM) into human-visible
//   fixed-width pulses on an LED/buzzer pin.
//   Enforces a minimum dark gap between pulses so back-to-back events stay distinguishable.
//   Optionally queues events that arrive while a pulse is already being shown.
// PARAMETERS
//   ON_CYCLES   25_000_000  clk_in cycles led_out is held high per event (>=1)
//   OFF_CYCLES  12_500_000  clk_in cycles led_out is forced low after each pulse (>=1)
//   QUEUE_MAX   7           max pending events stored (PULSE_QUEUE_EN only, >=1)
//   CNT_W       25          timer width; must hold max(ON_CYCLES,OFF_CYCLES)-1
// PORTS
//   clk_in    in   1               system clock; all logic on rising edge
//   rst_n     in   1               asynchronous, active-low reset
//   event_in  in   1               event request, one cycle per event, synchronous to clk_in
//   led_out   out  1               stretched indicator output, registered
//   busy      out  1               1 whenever state != IDLE
//   pending   out  clog2(QUEUE_MAX+1)  queued events not yet shown
//   dropped   out  1               1-cycle pulse: an event_in was discarded
// BEHAVIOUR
//   Reset: async on rst_n low -> state=IDLE, timer=0, pending=0, led_out=0, busy=0,
//     dropped=0; reset mid-pulse aborts immediately, queued events are lost.
//   FSM: IDLE -> ON -> GAP -> (ON | IDLE). All outputs registered.
//   IDLE: event_in=1 at edge k -> ON, led_out=1 from edge k+1 (latency 1 cycle).
//   ON: led_out=1 for exactly ON_CYCLES cycles (timer counts 0..ON_CYCLES-1), then GAP.
//   GAP: led_out=0 for exactly OFF_CYCLES cycles. On the last GAP cycle:
//     pending>0 -> pending-1, next ON; else event_in=1 -> next ON (direct, not queued);
//     else -> IDLE.
//   event_in=1 while ON or GAP (excluding the GAP-exit case above): queued, see CONFIGURATION.
//   Simultaneous queue-in and dequeue (last GAP cycle, pending>0, event_in=1):
//     pending unchanged, next ON.
//   Overflow: event_in=1 with pending==QUEUE_MAX (not dequeuing) -> discarded,
//     dropped=1 for one cycle; pending saturates, never wraps.
//   Timer reloads to 0 on every state change; no cycle is lost between back-to-back
//     pulses: period = ON_CYCLES+OFF_CYCLES exactly.
//   event_in held high for N cycles = N events.
// CONFIGURATION
//   PULSE_QUEUE_EN defined: busy-time events counted in pending (saturating at
//     QUEUE_MAX) and replayed in order.
//   PULSE_QUEUE_EN undefined: pending tied to 0; every event_in during ON/GAP,
//     except the GAP-exit case, is discarded with dropped=1 for one cycle.
//     No queue register is synthesized.
// TESTING (bench params: ON_CYCLES=4, OFF_CYCLES=2, QUEUE_MAX=3, CNT_W=3)
//   Reset: rst_n=0 mid-ON -> led_out, busy, pending, dropped all 0 immediately,
//     with no clock edge required.
//   Single event at edge 10 -> led_out=1 edges 11-14, 0 edges 15-16, IDLE at 17,
//     busy=1 at edges 11-16.
//   Events at edges 10 and 12 (queue on) -> pending=1 at 13; second pulse at edges
//     17-20; pending=0 at 17.
//   Event on last GAP cycle (edge 16) with pending=0 -> led_out=1 at edge 17,
//     pending stays 0, dropped=0.
//   event_in held for edges 10-15 (queue on) -> pending saturates at 3; dropped pulses
//     on the 2 excess events; 4 pulses total.
//   Queue off: event at edge 12 -> dropped=1 at edge 13, pending=0, only 1 pulse.

Source files
------------

// File: rtl/event_indicator.sv
// event_indicator: stretches single-cycle event pulses into fixed-width
// LED/buzzer pulses, with a minimum dark gap between consecutive pulses.
// Events that arrive while a pulse is shown are queued when PULSE_QUEUE_EN
// is defined; otherwise they are discarded and reported on dropped.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no pulse in progress, led_out low, waiting for event_in
// ON    | led_out high, timer counts 0..ON_CYCLES-1
// GAP   | led_out forced low, timer counts 0..OFF_CYCLES-1; on the last
//       | cycle either replay a queued event, take a fresh one, or go IDLE
module event_indicator #(
   parameter int unsigned ON_CYCLES  = 25_000_000,
   parameter int unsigned OFF_CYCLES = 12_500_000,
   parameter int unsigned QUEUE_MAX  = 7,
   parameter int unsigned CNT_W      = 25,
   localparam int unsigned PEND_W    = $clog2(QUEUE_MAX + 1)
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              event_in,
   output logic              led_out,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              dropped
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   timer_q, timer_d;
   logic               led_out_q, led_out_d;
   logic               busy_q, busy_d;
   logic               dropped_q, dropped_d;

   logic               gap_last;
   logic               has_pend;
   logic               ev_busy;

   // The final GAP cycle is where the next pulse (queued or fresh) is chosen.
   assign gap_last = (state_q == ST_GAP) && (timer_q == OFF_LAST);

   // An event that arrives while busy must be queued or dropped, except a
   // fresh event on the last GAP cycle with nothing queued: that one starts
   // the next pulse directly.
   assign ev_busy = event_in && (state_q != ST_IDLE) && !(gap_last && !has_pend);

   // Next-state, timer reload and registered-output decode.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      led_out_d = 1'b0;
      busy_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (event_in) begin
               state_d = ST_ON;
            end
         end
         ST_ON: begin
            if (timer_q == ON_LAST) begin
               state_d = ST_GAP;
               timer_d = '0;
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_last) begin
               timer_d = '0;
               if (has_pend || event_in) begin
                  state_d = ST_ON;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               timer_d = timer_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
         end
      endcase
      led_out_d = (state_d == ST_ON);
      busy_d    = (state_d != ST_IDLE);
   end

   // FSM state, timer and output registers.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         timer_q   <= '0;
         led_out_q <= 1'b0;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         led_out_q <= led_out_d;
         busy_q    <= busy_d;
         dropped_q <= dropped_d;
      end
   end

`ifdef PULSE_QUEUE_EN
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(QUEUE_MAX);

   logic [PEND_W-1:0] pending_q, pending_d;
   logic              deq;

   assign has_pend = (pending_q != '0);
   assign deq      = gap_last && has_pend;

   // Saturating event counter: a simultaneous enqueue and dequeue cancel out.
   always_comb begin
      pending_d = pending_q;
      dropped_d = 1'b0;
      if (ev_busy && !deq) begin
         if (pending_q == PEND_MAX) begin
            dropped_d = 1'b1;
         end else begin
            pending_d = pending_q + PEND_W'(1);
         end
      end else if (!ev_busy && deq) begin
         pending_d = pending_q - PEND_W'(1);
      end
   end

   // Queue depth register.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;
`else
   // Without a queue every busy-time event is discarded.
   assign has_pend  = 1'b0;
   assign dropped_d = ev_busy;
   assign pending   = '0;
`endif

   assign led_out = led_out_q;
   assign busy    = busy_q;
   assign dropped = dropped_q;

endmodule
